// File: rtl/fft_bus_pkg.sv
// Shared bus constants and FSM state encoding for the FFT peripheral initiator.
// The FFT peripheral's address decode imports this package as well.
package fft_bus_pkg;

    localparam logic [13:0] DATA_ADDR = 14'h0088;
    localparam logic [13:0] RES_ADDR  = 14'h0089;
    localparam logic [13:0] CTRL_ADDR = 14'h0090;
    localparam logic [13:0] STAT_ADDR = 14'h0098;

    localparam logic [1:0]  PER_WE_WORD = 2'b11;
    localparam logic [1:0]  PER_WE_RD   = 2'b00;

    localparam int          STAT_DONE  = 0;
    localparam logic [15:0] CTRL_START = 16'h0001;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_KICK      = 4'd2,
        ST_POLL_RD   = 4'd3,
        ST_POLL_WAIT = 4'd4,
        ST_POLL_GAP  = 4'd5,
        ST_DRAIN     = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } state_e;

endpackage

// File: rtl/per_access.sv
// Single-cycle registered peripheral-bus access driver. Bus outputs are zero
// whenever no access is in flight; read data is returned in the per_en cycle.
module per_access
    import fft_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [13:0] addr_i,
    input  logic [1:0]  we_i,
    input  logic [15:0] wdata_i,
    output logic [13:0] per_addr_o,
    output logic        per_en_o,
    output logic [1:0]  per_we_o,
    output logic [15:0] per_din_o,
    input  logic [15:0] per_dout_i,
    output logic        rd_valid_o,
    output logic [15:0] rd_data_o
);

    logic [13:0] per_addr_q;
    logic        per_en_q;
    logic [1:0]  per_we_q;
    logic [15:0] per_din_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_addr_q <= 14'h0;
            per_en_q   <= 1'b0;
            per_we_q   <= 2'b00;
            per_din_q  <= 16'h0;
        end else if (req_i) begin
            per_addr_q <= addr_i;
            per_en_q   <= 1'b1;
            per_we_q   <= we_i;
            per_din_q  <= wdata_i;
        end else begin
            per_addr_q <= 14'h0;
            per_en_q   <= 1'b0;
            per_we_q   <= 2'b00;
            per_din_q  <= 16'h0;
        end
    end

    assign per_addr_o = per_addr_q;
    assign per_en_o   = per_en_q;
    assign per_we_o   = per_we_q;
    assign per_din_o  = per_din_q;

    // The responder drives per_dout combinationally during the read cycle;
    // the caller captures it at the edge that ends that cycle.
    assign rd_valid_o = per_en_q && (per_we_q == PER_WE_RD);
    assign rd_data_o  = per_dout_i;

endmodule

// File: rtl/fft_bus_master.sv
// FFT peripheral initiator: streams N_WORDS samples in, starts the transform,
// polls for completion, then drains N_WORDS results onto a valid/ready stream.
module fft_bus_master
    import fft_bus_pkg::*;
#(
    parameter int N_WORDS   = 32,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        start,
    input  logic        smp_valid,
    output logic        smp_ready,
    input  logic [15:0] smp_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [13:0] per_addr,
    output logic        per_en,
    output logic [1:0]  per_we,
    output logic [15:0] per_din,
    input  logic [15:0] per_dout,
    output logic [3:0]  dbg_state
);

    // Handshakes: a sample moves when smp_valid && smp_ready in the same cycle;
    // a result moves when res_valid && res_ready. res_valid/res_data hold until taken.

    localparam int          PCW     = $clog2(MAX_POLLS + 1);
    localparam int          GCW     = $clog2(POLL_GAP + 1);
    localparam logic [5:0]  N_ALL   = 6'(N_WORDS);
    localparam logic [5:0]  N_LAST  = 6'(N_WORDS - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(MAX_POLLS - 1);
    localparam logic [GCW-1:0] GC_LAST = GCW'(POLL_GAP - 1);

    state_e         state_q, state_d;
    logic [5:0]     wc_q, wc_d;
    logic [5:0]     rc_q, rc_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [GCW-1:0] gc_q, gc_d;
    logic           res_valid_q, res_valid_d;
    logic [15:0]    res_data_q, res_data_d;

    logic           req;
    logic [13:0]    req_addr;
    logic [1:0]     req_we;
    logic [15:0]    req_wdata;
    logic           smp_ready_c;
    logic           rd_valid;
    logic [15:0]    rd_data;

    per_access u_per_access (
        .clk_i      (mclk),
        .rst_i      (puc_rst),
        .req_i      (req),
        .addr_i     (req_addr),
        .we_i       (req_we),
        .wdata_i    (req_wdata),
        .per_addr_o (per_addr),
        .per_en_o   (per_en),
        .per_we_o   (per_we),
        .per_din_o  (per_din),
        .per_dout_i (per_dout),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q     <= ST_IDLE;
            wc_q        <= 6'd0;
            rc_q        <= 6'd0;
            pc_q        <= '0;
            gc_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            rc_q        <= rc_d;
            pc_q        <= pc_d;
            gc_q        <= gc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        rc_d        = rc_q;
        pc_d        = pc_q;
        gc_d        = gc_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        req         = 1'b0;
        req_addr    = 14'h0;
        req_we      = PER_WE_RD;
        req_wdata   = 16'h0;
        smp_ready_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    wc_d    = 6'd0;
                    rc_d    = 6'd0;
                end
            end
            ST_LOAD: begin
                smp_ready_c = (wc_q < N_ALL);
                if (smp_valid && smp_ready_c) begin
                    req       = 1'b1;
                    req_addr  = DATA_ADDR;
                    req_we    = PER_WE_WORD;
                    req_wdata = smp_data;
                    wc_d      = wc_q + 6'd1;
                    if (wc_q == N_LAST) state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                req       = 1'b1;
                req_addr  = CTRL_ADDR;
                req_we    = PER_WE_WORD;
                req_wdata = CTRL_START;
                pc_d      = '0;
                state_d   = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                req      = 1'b1;
                req_addr = STAT_ADDR;
                state_d  = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (rd_valid) begin
                    if (rd_data[STAT_DONE]) begin
                        state_d = ST_DRAIN;
                        wc_d    = 6'd0;
                        rc_d    = 6'd0;
                    end else if (pc_q == PC_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        gc_d    = '0;
                        state_d = ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                // The last idle cycle also issues the next read so the gap is exact.
                if (gc_q == GC_LAST) begin
                    req      = 1'b1;
                    req_addr = STAT_ADDR;
                    state_d  = ST_POLL_WAIT;
                end else begin
                    gc_d = gc_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    wc_d        = wc_q + 6'd1;
                    if (wc_q == N_LAST) state_d = ST_DONE;
                end
                if (rd_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = rd_data;
                end
                if (!rd_valid && (!res_valid_q || res_ready) && (rc_q < N_ALL)) begin
                    req      = 1'b1;
                    req_addr = RES_ADDR;
                    rc_d     = rc_q + 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign smp_ready = smp_ready_c;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign dbg_state = state_q;

endmodule
